// File: rtl/inst_rom_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: bus widths, fetch FSM
// encoding and the wait-counter helper.
package inst_rom_responder_pkg;

    localparam int unsigned InstAddrBus = 32;
    localparam int unsigned InstBus     = 32;
    localparam int unsigned HalfBus     = 16;
    localparam int unsigned CntW        = 4;

    localparam logic [InstBus-1:0] ZERO_WORD = 32'h0;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRdHi = 2'd1,
        StRdLo = 2'd2,
        StDone = 2'd3
    } fetch_state_e;

    // Counter value loaded at the start of a half-word read; the read lasts
    // WAIT_CYCLES cycles counting down to zero inclusive.
    function automatic logic [CntW-1:0] wait_reload(input int unsigned cycles);
        return CntW'(cycles - 1);
    endfunction

endpackage

// File: rtl/inst_rom_responder_flash_halfword_reader.sv
// One 16-bit flash read: holds the half-word address with the strobes asserted
// for WAIT_CYCLES cycles and flags the final cycle so the caller can sample data.
module inst_rom_responder_flash_halfword_reader
    import inst_rom_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned FLASH_AW    = 22
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [FLASH_AW-1:0] half_addr_i,
    output logic [HalfBus-1:0]  data_o,
    output logic                done_o,
    output logic [FLASH_AW-1:0] flash_addr_o,
    input  logic [HalfBus-1:0]  flash_data_i,
    output logic                flash_ce_n_o,
    output logic                flash_oe_n_o
);

    logic                busy_q, busy_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [FLASH_AW-1:0] addr_q, addr_d;

    // Next-state: start (also used for back-to-back reads) beats abort beats countdown.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        if (start_i) begin
            busy_d = 1'b1;
            cnt_d  = wait_reload(WAIT_CYCLES);
            addr_d = half_addr_i;
        end else if (abort_i) begin
            busy_d = 1'b0;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Read state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    // Strobes follow the registered busy flag, so they are clean flop outputs.
    always_comb begin
        done_o       = busy_q && (cnt_q == '0);
        data_o       = flash_data_i;
        flash_addr_o = addr_q;
        flash_ce_n_o = ~busy_q;
        flash_oe_n_o = ~busy_q;
    end

endmodule

// File: rtl/inst_rom_responder.sv
// Instruction-fetch responder: serves IF from a one-entry word buffer and, on a
// miss, assembles a big-endian word from two wait-stated flash half-word reads.
module inst_rom_responder
    import inst_rom_responder_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter int unsigned FLASH_AW    = 22
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_i,
    input  logic [InstAddrBus-1:0] addr_i,
    output logic [InstBus-1:0]     inst_o,
    output logic                   ready_o,
    output logic                   stall_req_o,
    output logic [FLASH_AW-1:0]    flash_addr_o,
    input  logic [HalfBus-1:0]     flash_data_i,
    output logic                   flash_ce_n_o,
    output logic                   flash_oe_n_o
);

    fetch_state_e     state_q, state_d;
    logic [29:0]      req_addr_q, req_addr_d;
    logic [15:0]      hi_q, hi_d;
    logic [15:0]      lo_q, lo_d;
    logic             buf_valid_q, buf_valid_d;
    logic [29:0]      buf_tag_q, buf_tag_d;
    logic [InstBus-1:0] buf_data_q, buf_data_d;

    logic                rd_start, rd_abort, rd_done;
    logic [FLASH_AW-1:0] rd_half_addr;
    logic [HalfBus-1:0]  rd_data;

    logic               req_on;
    logic [29:0]        word_addr;
    logic               buf_hit, req_match;
    logic               ready_c, stall_c;
    logic [InstBus-1:0] inst_c;

    // Byte-lane bits never select anything; the fetch unit is word-aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    assign req_on    = (ce_i == ChipEnable);
    assign word_addr = addr_i[31:2];
    assign buf_hit   = req_on && buf_valid_q && (word_addr == buf_tag_q);
    assign req_match = req_on && (word_addr == req_addr_q);

    inst_rom_responder_flash_halfword_reader #(
        .WAIT_CYCLES(WAIT_CYCLES),
        .FLASH_AW   (FLASH_AW)
    ) u_reader (
        .clk         (clk),
        .rst         (rst),
        .start_i     (rd_start),
        .abort_i     (rd_abort),
        .half_addr_i (rd_half_addr),
        .data_o      (rd_data),
        .done_o      (rd_done),
        .flash_addr_o(flash_addr_o),
        .flash_data_i(flash_data_i),
        .flash_ce_n_o(flash_ce_n_o),
        .flash_oe_n_o(flash_oe_n_o)
    );

    // Fetch sequencing: hit/miss decision, two half-word reads, buffer fill.
    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        buf_valid_d  = buf_valid_q;
        buf_tag_d    = buf_tag_q;
        buf_data_d   = buf_data_q;
        rd_start     = 1'b0;
        rd_abort     = 1'b0;
        rd_half_addr = {req_addr_q[FLASH_AW-2:0], 1'b1};
        ready_c      = 1'b0;
        stall_c      = 1'b0;
        inst_c       = ZERO_WORD;
        unique case (state_q)
            StIdle: begin
                if (buf_hit) begin
                    ready_c = 1'b1;
                    inst_c  = buf_data_q;
                end else if (req_on) begin
                    stall_c      = 1'b1;
                    req_addr_d   = word_addr;
                    rd_start     = 1'b1;
                    rd_half_addr = {addr_i[FLASH_AW:2], 1'b0};
                    state_d      = StRdHi;
                end
            end
            StRdHi: begin
                if (!req_on) begin
                    rd_abort = 1'b1;
                    state_d  = StIdle;
                end else begin
                    stall_c = 1'b1;
                    if (rd_done) begin
                        hi_d     = rd_data;
                        rd_start = 1'b1;
                        state_d  = StRdLo;
                    end
                end
            end
            StRdLo: begin
                if (!req_on) begin
                    rd_abort = 1'b1;
                    state_d  = StIdle;
                end else begin
                    stall_c = 1'b1;
                    if (rd_done) begin
                        lo_d    = rd_data;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Buffer is filled even when IF has moved on, e.g. after a flush.
                buf_valid_d = 1'b1;
                buf_tag_d   = req_addr_q;
                buf_data_d  = {hi_q, lo_q};
                if (req_match) begin
                    ready_c = 1'b1;
                    inst_c  = {hi_q, lo_q};
                end else begin
                    stall_c = req_on;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // All responder state, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= ZERO_WORD;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    // Reset forces the IF-facing outputs quiet even while ce_i is still high.
    always_comb begin
        ready_o     = ready_c && !rst;
        stall_req_o = stall_c && !rst;
        inst_o      = rst ? ZERO_WORD : inst_c;
    end

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: transaction-level reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_inst_rom_responder;

    localparam int W   = 3;
    localparam int AW  = 22;
    localparam int LAT = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce_i;
    logic [31:0]   addr_i;
    logic [31:0]   inst_o;
    logic          ready_o;
    logic          stall_req_o;
    logic [AW-1:0] flash_addr_o;
    logic [15:0]   flash_data_i;
    logic          flash_ce_n_o;
    logic          flash_oe_n_o;

    int checks   = 0;
    int failures = 0;

    inst_rom_responder #(
        .WAIT_CYCLES(W),
        .FLASH_AW   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_i),
        .addr_i      (addr_i),
        .inst_o      (inst_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o),
        .flash_addr_o(flash_addr_o),
        .flash_data_i(flash_data_i),
        .flash_ce_n_o(flash_ce_n_o),
        .flash_oe_n_o(flash_oe_n_o)
    );

    always #5 clk = ~clk;

    // Flash contents: a few program words, everything else a fixed pattern.
    function automatic logic [15:0] flash_fn(input logic [AW-1:0] h);
        case (h)
            22'h000: return 16'h3C01;
            22'h001: return 16'h8000;
            22'h002: return 16'h3421;
            22'h003: return 16'h0020;
            default: return h[15:0] ^ 16'hA5A5;
        endcase
    endfunction

    always_comb flash_data_i = flash_fn(flash_addr_o);

    function automatic logic [AW-1:0] half_of(input logic [29:0] w, input logic lo);
        return {w[AW-2:0], lo};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch is an "age" counted from its request cycle.
    logic        m_valid;
    logic [29:0] m_tag;
    logic [31:0] m_data;
    logic [29:0] m_req;
    int          m_age;

    initial begin
        logic          e_ready, e_stall, e_on;
        logic [31:0]   e_inst, word;
        logic [AW-1:0] e_faddr;
        m_valid = 1'b0; m_tag = '0; m_data = '0; m_req = '0; m_age = 0;
        forever begin
            @(negedge clk);
            e_ready = 1'b0; e_stall = 1'b0; e_on = 1'b0; e_inst = '0; e_faddr = '0;
            if (rst) begin
                m_valid = 1'b0; m_tag = '0; m_data = '0; m_age = 0;
            end else if (m_age >= 1 && m_age <= 2 * W) begin
                e_on    = 1'b1;
                e_faddr = half_of(m_req, (m_age > W));
                e_stall = ce_i;
                m_age   = ce_i ? m_age + 1 : 0;
            end else if (m_age == LAT) begin
                word    = {flash_fn(half_of(m_req, 1'b0)), flash_fn(half_of(m_req, 1'b1))};
                e_ready = ce_i && (addr_i[31:2] == m_req);
                e_inst  = e_ready ? word : 32'h0;
                e_stall = ce_i && !e_ready;
                m_valid = 1'b1; m_tag = m_req; m_data = word; m_age = 0;
            end else if (ce_i) begin
                if (m_valid && addr_i[31:2] == m_tag) begin
                    e_ready = 1'b1;
                    e_inst  = m_data;
                end else begin
                    e_stall = 1'b1;
                    m_req   = addr_i[31:2];
                    m_age   = 1;
                end
            end
            chk("model_ready", ready_o, e_ready);
            chk("model_inst", inst_o, e_inst);
            chk("model_stall", stall_req_o, e_stall);
            chk("model_ce_n", flash_ce_n_o, !e_on);
            chk("model_oe_n", flash_oe_n_o, !e_on);
            if (e_on || rst) chk("model_faddr", flash_addr_o, e_faddr);
        end
    end

    // One clock cycle: inputs applied just after the edge, then wait for the sampling point.
    task automatic cyc(input logic r, input logic c, input logic [31:0] a);
        @(posedge clk);
        #1;
        rst = r; ce_i = c; addr_i = a;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int stalls;
        rst = 1'b1; ce_i = 1'b1; addr_i = 32'h0;
        @(negedge clk);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_stall", stall_req_o, 1'b0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_faddr", flash_addr_o, 22'h0);
        chk("rst_ce_n", flash_ce_n_o, 1'b1);
        chk("rst_oe_n", flash_oe_n_o, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);

        // Reset then miss on word 0.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 32'h0);
            if (i < 7) begin
                chk("t1_stall", stall_req_o, 1'b1);
                chk("t1_not_ready", ready_o, 1'b0);
            end
            if (i >= 1 && i <= 6) begin
                chk("t1_faddr", flash_addr_o, (i <= 3) ? 22'h000 : 22'h001);
                chk("t1_ce_n", flash_ce_n_o, 1'b0);
            end
            if (i == 7) begin
                chk("t1_ready", ready_o, 1'b1);
                chk("t1_inst", inst_o, 32'h3C01_8000);
                chk("t1_stall_done", stall_req_o, 1'b0);
            end
        end

        // Hit after miss.
        cyc(1'b0, 1'b1, 32'h0);
        chk("t2_ready", ready_o, 1'b1);
        chk("t2_stall", stall_req_o, 1'b0);
        chk("t2_inst", inst_o, 32'h3C01_8000);
        chk("t2_ce_n", flash_ce_n_o, 1'b1);

        // Sequential miss.
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 1'b1, 32'h4);
            if (stall_req_o === 1'b1) stalls++;
            if (i >= 1 && i <= 6)
                chk("t3_faddr", flash_addr_o, (i <= 3) ? 22'h002 : 22'h003);
            if (i == 7) begin
                chk("t3_ready", ready_o, 1'b1);
                chk("t3_inst", inst_o, 32'h3421_0020);
            end
        end
        chk("t3_stall_cycles", stalls, 7);

        // Abort in the second cycle of the low read.
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 32'h8);
        cyc(1'b0, 1'b0, 32'h8);
        chk("t4_abort_stall", stall_req_o, 1'b0);
        chk("t4_abort_ready", ready_o, 1'b0);
        cyc(1'b0, 1'b0, 32'h8);
        chk("t4_after_ce_n", flash_ce_n_o, 1'b1);
        chk("t4_after_stall", stall_req_o, 1'b0);
        n = 0;
        cyc(1'b0, 1'b1, 32'h8);
        chk("t4_rereq_stall", stall_req_o, 1'b1);
        while (ready_o !== 1'b1 && n < 20) begin
            cyc(1'b0, 1'b1, 32'h8);
            n++;
        end
        chk("t4_latency", n, 7);
        chk("t4_inst", inst_o, 32'hA5A1_A5A0);

        // Flush: address changes mid-read, old request completes without ready.
        cyc(1'b0, 1'b1, 32'h10);
        cyc(1'b0, 1'b1, 32'h10);
        for (int i = 2; i < 7; i++) begin
            cyc(1'b0, 1'b1, 32'h100);
            if (i == 5) chk("t5_faddr_kept", flash_addr_o, 22'h009);
        end
        cyc(1'b0, 1'b1, 32'h100);
        chk("t5_done_not_ready", ready_o, 1'b0);
        chk("t5_done_ce_n", flash_ce_n_o, 1'b1);
        n = 0;
        cyc(1'b0, 1'b1, 32'h100);
        chk("t5_refetch_stall", stall_req_o, 1'b1);
        while (ready_o !== 1'b1 && n < 20) begin
            cyc(1'b0, 1'b1, 32'h100);
            n++;
            if (n == 1) chk("t5_new_faddr", flash_addr_o, 22'h080);
        end
        chk("t5_latency", n, 7);
        chk("t5_inst", inst_o, 32'hA525_A524);

        // Asynchronous reset in the middle of the high read.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 32'h20);
        chk("t6_pre_ce_n", flash_ce_n_o, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ce_n", flash_ce_n_o, 1'b1);
        chk("t6_async_stall", stall_req_o, 1'b0);
        chk("t6_async_inst", inst_o, 32'h0);
        chk("t6_async_ready", ready_o, 1'b0);
        @(negedge clk);
        n = 0;
        cyc(1'b0, 1'b1, 32'h0);
        chk("t6_miss_stall", stall_req_o, 1'b1);
        chk("t6_miss_ready", ready_o, 1'b0);
        while (ready_o !== 1'b1 && n < 20) begin
            cyc(1'b0, 1'b1, 32'h0);
            n++;
        end
        chk("t6_latency", n, 7);
        chk("t6_inst", inst_o, 32'h3C01_8000);

        cyc(1'b0, 1'b0, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
